// File: rtl/startup_pattern_seq_tmr_pkg.sv
// Shared FSM package: state encodings, output bundle and decode helpers
// for the display/startup sequencers (3-bit state, Idle = 0).
package startup_pattern_seq_tmr_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_WAIT = 3'd2,
        S_NEXT = 3'd3,
        S_SKIP = 3'd4,
        S_END  = 3'd5
    } state_e;

    typedef struct packed {
        logic tmr_err;
        logic busy;
        logic nxt_adr;
        logic load_pat;
        logic disp;
        logic clear;
    } out_t;

    localparam int OUT_W = $bits(out_t);

    localparam out_t OUT_RST = '{
        tmr_err:  1'b0,
        busy:     1'b0,
        nxt_adr:  1'b0,
        load_pat: 1'b0,
        disp:     1'b1,
        clear:    1'b0
    };

    // Unused encodings collapse to Idle.
    function automatic state_e to_state(logic [2:0] v);
        case (v)
            3'd1:    return S_LOAD;
            3'd2:    return S_WAIT;
            3'd3:    return S_NEXT;
            3'd4:    return S_SKIP;
            3'd5:    return S_END;
            default: return S_IDLE;
        endcase
    endfunction

    // Level/pulse outputs for the state being entered.
    function automatic out_t decode_out(state_e s);
        out_t o;
        o          = '0;
        o.clear    = (s == S_IDLE) || (s == S_END);
        o.disp     = !o.clear;
        o.busy     = !o.clear;
        o.load_pat = (s == S_LOAD);
        o.nxt_adr  = (s == S_NEXT);
        return o;
    endfunction

endpackage

// File: rtl/startup_pattern_seq_tmr_vote.sv
// tmr_vote: bitwise 2-of-3 majority voter with disagreement flag.
// Ports: in_a/in_b/in_c replicas, voted majority, mismatch = any bit differs.
module tmr_vote #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    output logic [WIDTH-1:0] voted,
    output logic             mismatch
);

    assign voted    = (in_a & in_b) | (in_a & in_c) | (in_b & in_c);
    assign mismatch = (in_a != in_b) || (in_a != in_c);

endmodule

// File: rtl/startup_pattern_seq_tmr.sv
// Triplicated startup pattern sequencer: Load/Wait/Next/Skip per pattern,
// optional looping, abort to End, sticky replica-disagreement flag.
// Ports: CLK, RST (async, active-high), RUN, LOOP, ABORT in;
//        CLEAR, DISP, LOAD_PAT, NXT_ADR, ADDR, BUSY, TMR_ERR out.
module startup_pattern_seq_tmr
    import startup_pattern_seq_tmr_pkg::*;
#(
    parameter int DWELL_W = 16,
    parameter int DWELL   = 3000,
    parameter int ADDR_W  = 4,
    parameter int NPAT    = 12
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RUN,
    input  logic              LOOP,
    input  logic              ABORT,
    output logic              CLEAR,
    output logic              DISP,
    output logic              LOAD_PAT,
    output logic              NXT_ADR,
    output logic [ADDR_W-1:0] ADDR,
    output logic              BUSY,
    output logic              TMR_ERR
);

    localparam int                OV_W     = OUT_W + ADDR_W;
    localparam logic [DWELL_W-1:0] DWELL_M1 = DWELL_W'(DWELL - 1);
    localparam logic [ADDR_W-1:0]  LAST     = ADDR_W'(NPAT - 1);

    state_e              state_0_q, state_1_q, state_2_q, state_d;
    logic [DWELL_W-1:0]  timer_0_q, timer_1_q, timer_2_q, timer_d;
    logic [ADDR_W-1:0]   addr_0_q, addr_1_q, addr_2_q, addr_d;
    out_t                out_0_q, out_1_q, out_2_q, out_d;
    logic [ADDR_W-1:0]   adr_o_0_q, adr_o_1_q, adr_o_2_q, adr_o_d;

    logic [2:0]          state_raw;
    state_e              state_v;
    logic [DWELL_W-1:0]  timer_v;
    logic [ADDR_W-1:0]   addr_v;
    logic [ADDR_W-1:0]   addr_adv;
    logic [OV_W-1:0]     ov;
    out_t                out_v;
    logic                state_mis, timer_mis, addr_mis;
    logic                out_mis_unused;

    tmr_vote #(.WIDTH(3)) u_vote_state (
        .in_a     (state_0_q),
        .in_b     (state_1_q),
        .in_c     (state_2_q),
        .voted    (state_raw),
        .mismatch (state_mis)
    );

    tmr_vote #(.WIDTH(DWELL_W)) u_vote_timer (
        .in_a     (timer_0_q),
        .in_b     (timer_1_q),
        .in_c     (timer_2_q),
        .voted    (timer_v),
        .mismatch (timer_mis)
    );

    tmr_vote #(.WIDTH(ADDR_W)) u_vote_addr (
        .in_a     (addr_0_q),
        .in_b     (addr_1_q),
        .in_c     (addr_2_q),
        .voted    (addr_v),
        .mismatch (addr_mis)
    );

    tmr_vote #(.WIDTH(OV_W)) u_vote_out (
        .in_a     ({out_0_q, adr_o_0_q}),
        .in_b     ({out_1_q, adr_o_1_q}),
        .in_c     ({out_2_q, adr_o_2_q}),
        .voted    (ov),
        .mismatch (out_mis_unused)
    );

    assign state_v = to_state(state_raw);
    assign out_v   = ov[OV_W-1:ADDR_W];

    // Address after the current pattern: wrap when looping, else hold.
    assign addr_adv = (addr_v != LAST) ? addr_v + ADDR_W'(1)
                    : (LOOP ? '0 : LAST);

    always_comb begin
        state_d = state_v;
        timer_d = '0;
        addr_d  = addr_v;
        case (state_v)
            S_IDLE: begin
                if (RUN) begin
                    state_d = S_LOAD;
                    addr_d  = '0;
                end
            end
            S_LOAD: state_d = S_WAIT;
            S_WAIT: begin
                if (timer_v == DWELL_M1) begin
                    state_d = S_NEXT;
                end else begin
                    timer_d = timer_v + DWELL_W'(1);
                end
            end
            S_NEXT: begin
                state_d = (addr_v != LAST || LOOP) ? S_SKIP : S_END;
                addr_d  = addr_adv;
            end
            S_SKIP: state_d = S_LOAD;
            S_END:  if (!RUN) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (ABORT && (state_v == S_LOAD || state_v == S_WAIT ||
                      state_v == S_NEXT || state_v == S_SKIP)) begin
            state_d = S_END;
            timer_d = '0;
        end
        // ADDR shows the advanced address together with NXT_ADR.
        adr_o_d = (state_d == S_NEXT) ? addr_adv : addr_d;
        out_d         = decode_out(state_d);
        out_d.tmr_err = out_v.tmr_err | state_mis | timer_mis | addr_mis;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_0_q <= S_IDLE;
            state_1_q <= S_IDLE;
            state_2_q <= S_IDLE;
            timer_0_q <= '0;
            timer_1_q <= '0;
            timer_2_q <= '0;
            addr_0_q  <= '0;
            addr_1_q  <= '0;
            addr_2_q  <= '0;
            out_0_q   <= OUT_RST;
            out_1_q   <= OUT_RST;
            out_2_q   <= OUT_RST;
            adr_o_0_q <= '0;
            adr_o_1_q <= '0;
            adr_o_2_q <= '0;
        end else begin
            state_0_q <= state_d;
            state_1_q <= state_d;
            state_2_q <= state_d;
            timer_0_q <= timer_d;
            timer_1_q <= timer_d;
            timer_2_q <= timer_d;
            addr_0_q  <= addr_d;
            addr_1_q  <= addr_d;
            addr_2_q  <= addr_d;
            out_0_q   <= out_d;
            out_1_q   <= out_d;
            out_2_q   <= out_d;
            adr_o_0_q <= adr_o_d;
            adr_o_1_q <= adr_o_d;
            adr_o_2_q <= adr_o_d;
        end
    end

    assign CLEAR    = out_v.clear;
    assign DISP     = out_v.disp;
    assign LOAD_PAT = out_v.load_pat;
    assign NXT_ADR  = out_v.nxt_adr;
    assign BUSY     = out_v.busy;
    assign TMR_ERR  = out_v.tmr_err;
    assign ADDR     = ov[ADDR_W-1:0];

endmodule

// File: tb/tb_startup_pattern_seq_tmr.sv
// Bench for startup_pattern_seq_tmr: DWELL=5 and DWELL=1 instances (NPAT=4)
// driven in lockstep, checked against a pattern-position model.
module tb_startup_pattern_seq_tmr;
    import startup_pattern_seq_tmr_pkg::*;

    localparam int NP = 4;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic RUN = 1'b0;
    logic LOOP = 1'b0;
    logic ABORT = 1'b0;

    logic c5, d5, l5, n5, b5, e5;
    logic [3:0] a5;
    logic c1, d1, l1, n1, b1, e1;
    logic [3:0] a1;

    startup_pattern_seq_tmr #(
        .DWELL_W(16), .DWELL(5), .ADDR_W(4), .NPAT(NP)
    ) dut (
        .CLK(CLK), .RST(RST), .RUN(RUN), .LOOP(LOOP), .ABORT(ABORT),
        .CLEAR(c5), .DISP(d5), .LOAD_PAT(l5), .NXT_ADR(n5),
        .ADDR(a5), .BUSY(b5), .TMR_ERR(e5)
    );

    startup_pattern_seq_tmr #(
        .DWELL_W(16), .DWELL(1), .ADDR_W(4), .NPAT(NP)
    ) dut1 (
        .CLK(CLK), .RST(RST), .RUN(RUN), .LOOP(LOOP), .ABORT(ABORT),
        .CLEAR(c1), .DISP(d1), .LOAD_PAT(l1), .NXT_ADR(n1),
        .ADDR(a1), .BUSY(b1), .TMR_ERR(e1)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       clear;
        logic       disp;
        logic       load;
        logic       nxt;
        logic       busy;
        logic       err;
        logic [3:0] addr;
    } exp_t;

    // mode: 0 idle, 1 running, 2 end, 3 in reset
    // pos: 0 Load, 1..dw Wait, dw+1 Next, dw+2 Skip
    typedef struct {
        int mode;
        int pos;
        int pat;
        bit fin;
    } mdl_t;

    typedef struct {
        bit run;
        bit loop;
        bit abort;
        int ncyc;
        int loads;
        int nxts;
        bit clear;
        bit busy;
        int addr;
    } seg_t;

    typedef struct packed {
        logic [7:0] loads;
        logic [7:0] nxts;
        logic       clear;
        logic       busy;
        logic [3:0] addr;
    } sum_t;

    int   n_vec = 0;
    int   n_bad = 0;
    int   loads = 0;
    int   nxts = 0;
    int   loads1 = 0;
    bit   err5 = 1'b0;
    mdl_t m5, m1;
    exp_t q5[$];
    exp_t q1[$];
    seg_t tbl[12];

    function automatic mdl_t mnext(mdl_t m, int dw, bit r, bit l, bit a);
        mdl_t n;
        n = m;
        case (m.mode)
            0, 3: begin
                if (r) begin
                    n.mode = 1;
                    n.pos  = 0;
                    n.pat  = 0;
                end else begin
                    n.mode = 0;
                end
            end
            2: n.mode = r ? 2 : 0;
            default: begin
                if (a) begin
                    n.mode = 2;
                end else if (m.pos == dw + 1) begin
                    if (m.fin) n.mode = 2;
                    else n.pos = dw + 2;
                end else if (m.pos == dw + 2) begin
                    n.pos = 0;
                end else begin
                    n.pos = m.pos + 1;
                    if (n.pos == dw + 1) begin
                        n.fin = (m.pat == NP - 1) && !l;
                        if (m.pat != NP - 1) n.pat = m.pat + 1;
                        else if (l) n.pat = 0;
                    end
                end
            end
        endcase
        return n;
    endfunction

    function automatic exp_t mexp(mdl_t m, int dw, bit err);
        exp_t e;
        e      = '0;
        e.err  = err;
        e.addr = 4'(m.pat);
        case (m.mode)
            1: begin
                e.disp = 1'b1;
                e.busy = 1'b1;
                e.load = (m.pos == 0);
                e.nxt  = (m.pos == dw + 1);
            end
            3: begin
                e.disp = 1'b1;
                e.addr = 4'd0;
            end
            default: e.clear = 1'b1;
        endcase
        return e;
    endfunction

    task automatic check(string nm, exp_t got, exp_t req);
        n_vec++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s t=%0t got c/d/l/n/b/e/a=%b required=%b",
                     nm, $time, got, req);
        end
    endtask

    task automatic check_both();
        exp_t g;
        g = {c5, d5, l5, n5, b5, e5, a5};
        check("dwell5", g, q5.pop_front());
        g = {c1, d1, l1, n1, b1, e1, a1};
        check("dwell1", g, q1.pop_front());
    endtask

    task automatic step(input bit r, input bit l, input bit a);
        RUN   = r;
        LOOP  = l;
        ABORT = a;
        m5 = mnext(m5, 5, r, l, a);
        m1 = mnext(m1, 1, r, l, a);
        q5.push_back(mexp(m5, 5, err5));
        q1.push_back(mexp(m1, 1, 1'b0));
        @(posedge CLK);
        @(negedge CLK);
        if (l5) loads++;
        if (n5) nxts++;
        if (l1) loads1++;
        check_both();
    endtask

    task automatic enter_reset();
        m5 = '{mode: 3, pos: 0, pat: 0, fin: 1'b0};
        m1 = '{mode: 3, pos: 0, pat: 0, fin: 1'b0};
        err5 = 1'b0;
        q5.push_back(mexp(m5, 5, 1'b0));
        q1.push_back(mexp(m1, 1, 1'b0));
        #1;
        check_both();
    endtask

    initial begin
        sum_t sg, sr;
        tbl[0]  = '{0, 0, 0,  2, 0, 0, 1, 0, 0};
        tbl[1]  = '{1, 0, 0,  1, 1, 0, 0, 1, 0};
        tbl[2]  = '{0, 0, 0, 31, 3, 4, 1, 0, 3};
        tbl[3]  = '{0, 0, 0,  2, 0, 0, 1, 0, 3};
        tbl[4]  = '{1, 1, 0,  1, 1, 0, 0, 1, 0};
        tbl[5]  = '{0, 1, 0, 40, 5, 5, 0, 1, 1};
        tbl[6]  = '{0, 1, 0,  3, 0, 0, 0, 1, 1};
        tbl[7]  = '{0, 1, 1,  1, 0, 0, 1, 0, 1};
        tbl[8]  = '{1, 1, 0,  3, 0, 0, 1, 0, 1};
        tbl[9]  = '{0, 1, 0,  1, 0, 0, 1, 0, 1};
        tbl[10] = '{1, 0, 0,  1, 1, 0, 0, 1, 0};
        tbl[11] = '{0, 0, 0,  8, 1, 1, 0, 1, 1};

        #2 RST = 1'b1;
        enter_reset();
        @(negedge CLK);
        enter_reset();
        RST = 1'b0;

        for (int i = 0; i < 12; i++) begin
            loads = 0;
            nxts  = 0;
            for (int k = 0; k < tbl[i].ncyc; k++)
                step(tbl[i].run, tbl[i].loop, tbl[i].abort);
            sg = {8'(loads), 8'(nxts), c5, b5, a5};
            sr = {8'(tbl[i].loads), 8'(tbl[i].nxts),
                  tbl[i].clear, tbl[i].busy, 4'(tbl[i].addr)};
            n_vec++;
            if (sg !== sr) begin
                n_bad++;
                $display("FAIL seg%0d got ld/nx/clr/busy/adr=%h required=%h",
                         i, sg, sr);
            end
        end

        // Upset one state replica during Wait: outputs must not move.
        step(0, 0, 0);
        step(0, 0, 0);
        force dut.state_2_q = S_NEXT;
        err5 = 1'b1;
        step(0, 0, 0);
        release dut.state_2_q;
        step(0, 0, 0);
        n_vec++;
        if (dut.state_2_q !== S_WAIT) begin
            n_bad++;
            $display("FAIL resync got=%0d required=%0d",
                     dut.state_2_q, S_WAIT);
        end
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);

        // Reset while in Skip takes effect without waiting for a clock.
        RST = 1'b1;
        enter_reset();
        @(posedge CLK);
        @(negedge CLK);
        enter_reset();
        RST = 1'b0;
        step(0, 0, 0);

        loads1 = 0;
        step(1, 0, 0);
        for (int k = 0; k < 20; k++) step(0, 0, 0);
        n_vec++;
        if (loads1 != 4) begin
            n_bad++;
            $display("FAIL dwell1_loads got=%0d required=4", loads1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
